uart_rx_os: RTL

Oversampling UART receiver that replaces the fixed-divider RX path and its 3-tap majority filter. Adds a configurable frame format (data bits, parity mode, stop bits) and an optional run-time baud divisor. It reports parity, framing and overrun errors per word. Received words are delivered through a valid/ready holding register, so a downstream FIFO or bus bridge can stall the receiver.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_filter.sv | 42 ++++
 rtl/uart_rx_os.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    // Oversample tick period minus one for a fixed clock/baud pair.
    function automatic int default_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Two-flop synchronizer followed by an M_TAPS shift register and a registered
// majority vote; removes single-cycle glitches from the asynchronous line.
module uart_rx_filter #(
    parameter int M_TAPS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(M_TAPS + 1);
    localparam logic [CW-1:0] HALF = CW'(M_TAPS / 2);

    logic [1:0]        sync_reg;
    logic [M_TAPS-1:0] taps_reg;
    logic [CW-1:0]     ones;
    logic              dout_reg;

    always_comb begin
        ones = '0;
        for (int i = 0; i < M_TAPS; i++) begin
            ones = ones + CW'(taps_reg[i]);
        end
    end

    // Everything resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
            taps_reg <= '1;
            dout_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], din};
            taps_reg <= {taps_reg[M_TAPS-2:0], sync_reg[1]};
            dout_reg <= (ones > HALF);
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable frame format, per-word error
// flags and a valid/ready holding register that can stall the receiver.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int M_TAPS     = 3,
    parameter int USE_RT_DIV = 0,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam parity_t PAR_MODE = parity_t'(2'(PARITY));
    localparam logic    ODD_REF  = (PAR_MODE == PAR_ODD);
    localparam int      OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] CONST_DIV =
        DIV_WIDTH'(default_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE));

    logic rx_f;

    uart_rx_filter #(
        .M_TAPS (M_TAPS)
    ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (uart_rx),
        .dout (rx_f)
    );

    rx_state_t             state_reg;
    logic [OS_W-1:0]       os_cnt_reg;
    logic [3:0]            bit_cnt_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  rx_prev_reg;
    logic                  par_err_reg;
    logic                  stop_err_reg;
    logic                  busy_reg;

    logic [DIV_WIDTH-1:0]  div_reg;
    logic [DIV_WIDTH-1:0]  tick_cnt_reg;
    logic [DIV_WIDTH-1:0]  div_sel;

    logic [DATA_BITS-1:0]  dout_reg;
    logic                  vld_reg;
    logic                  perr_reg;
    logic                  ferr_reg;
    logic                  ovr_reg;

    logic start_go;
    logic tick;
    logic bit_end;
    logic commit;
    logic commit_perr;
    logic commit_ferr;

    assign div_sel  = (USE_RT_DIV != 0) ? baud_div : CONST_DIV;
    assign start_go = (state_reg == IDLE) && rx_prev_reg && !rx_f;
    assign tick     = (tick_cnt_reg == div_reg);
    assign bit_end  = tick && (os_cnt_reg == OS_LAST);

    always_comb begin
        commit      = (state_reg == STOP) && bit_end && (bit_cnt_reg == STOP_LAST);
        commit_perr = (PAR_MODE != PAR_NONE) && par_err_reg;
        commit_ferr = stop_err_reg || !rx_f;
    end

    // The tick phase restarts at every detected start edge so the half-bit
    // start sample lands at the same offset into every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg      <= '0;
            tick_cnt_reg <= '0;
        end else if (start_go) begin
            div_reg      <= div_sel;
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            rx_prev_reg  <= 1'b1;
            par_err_reg  <= 1'b0;
            stop_err_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rx_prev_reg <= rx_f;
            case (state_reg)
                IDLE: begin
                    if (start_go) begin
                        state_reg    <= START;
                        os_cnt_reg   <= '0;
                        bit_cnt_reg  <= '0;
                        par_err_reg  <= 1'b0;
                        stop_err_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt_reg == OS_HALF) begin
                            os_cnt_reg <= '0;
                            if (rx_f) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg <= DATA;
                            end
                        end else begin
                            os_cnt_reg <= os_cnt_reg + OS_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        os_cnt_reg <= '0;
                        shift_reg  <= {rx_f, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (PAR_MODE != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else if (tick) begin
                        os_cnt_reg <= os_cnt_reg + OS_W'(1);
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        os_cnt_reg  <= '0;
                        par_err_reg <= ((^shift_reg) ^ rx_f) != ODD_REF;
                        state_reg   <= STOP;
                    end else if (tick) begin
                        os_cnt_reg <= os_cnt_reg + OS_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        os_cnt_reg   <= '0;
                        stop_err_reg <= stop_err_reg || !rx_f;
                        // Return to IDLE at the last stop sample, not at the end of the bit.
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else if (tick) begin
                        os_cnt_reg <= os_cnt_reg + OS_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // A frame arriving while the held word is still pending is dropped and
    // only leaves a sticky overrun mark on the word that is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg <= '0;
            vld_reg  <= 1'b0;
            perr_reg <= 1'b0;
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;
        end else if (commit && (!vld_reg || dout_rdy)) begin
            dout_reg <= shift_reg;
            vld_reg  <= 1'b1;
            perr_reg <= commit_perr;
            ferr_reg <= commit_ferr;
            ovr_reg  <= 1'b0;
        end else if (commit) begin
            ovr_reg <= 1'b1;
        end else if (vld_reg && dout_rdy) begin
            vld_reg  <= 1'b0;
            perr_reg <= 1'b0;
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;
        end
    end

    assign dout       = dout_reg;
    assign dout_vld   = vld_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;
    assign overrun    = ovr_reg;
    assign busy       = busy_reg;

endmodule
